// File: rtl/clk_period_meter_pkg.sv
// rtl/clk_period_meter_pkg.sv - shared types, constants and helpers for the period meter
package clk_period_meter_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } meter_state_t;

    // Adds two values of w bits (w <= 64) and clamps the result to all-ones.
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b, input int w);
        logic [64:0] sum;
        logic [63:0] max_val;
        sum     = {1'b0, a} + {1'b0, b};
        max_val = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (sum > {1'b0, max_val}) ? max_val : sum[63:0];
    endfunction

endpackage

// File: rtl/clk_period_meter_if.sv
// rtl/clk_period_meter_if.sv - control and result bundle of the period meter
interface clk_period_meter_if import clk_period_meter_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             enable;
    logic [WIDTH-1:0] timeout_count;
    logic [WIDTH-1:0] high_count;
    logic [WIDTH-1:0] low_count;
    logic [WIDTH-1:0] period_count;
    logic             meas_valid;
    logic             timeout;
    logic             signal_present;

    modport master (
        output enable, timeout_count,
        input  high_count, low_count, period_count, meas_valid, timeout, signal_present
    );

    modport slave (
        input  enable, timeout_count,
        output high_count, low_count, period_count, meas_valid, timeout, signal_present
    );

endinterface

// File: rtl/clk_period_meter_sig_sync_edge.sv
// rtl/clk_period_meter_sig_sync_edge.sv - synchronizer plus history flop with rise/fall strobes
module sig_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic inclk,
    input  logic Reset,
    input  logic sig_in,
    output logic sync_level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   hist_r;

    always_ff @(posedge inclk) begin
        if (Reset) begin
            sync_r <= '0;
            hist_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], sig_in};
            hist_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign sync_level = sync_r[SYNC_STAGES-1];
    assign rise       = sync_level & ~hist_r;
    assign fall       = ~sync_level & hist_r;

endmodule

// File: rtl/clk_period_meter.sv
// rtl/clk_period_meter.sv - recovers high, low and full period counts of a slow square wave
module clk_period_meter import clk_period_meter_pkg::*; #(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             inclk,
    input  logic             Reset,
    input  logic             sig_in,
    clk_period_meter_if.slave bus
);

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    meter_state_t     state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
    logic [WIDTH-1:0] high_tmp_q, high_tmp_d;
    logic [WIDTH-1:0] high_q, high_d, low_q, low_d, period_q, period_d;
    logic             valid_q, valid_d, tmo_q, tmo_d, present_q, present_d;
    logic             sync_level, rise, fall, timeout_hit;

    sig_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .inclk      (inclk),
        .Reset      (Reset),
        .sig_in     (sig_in),
        .sync_level (sync_level),
        .rise       (rise),
        .fall       (fall)
    );

    assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
    assign timeout_hit = (bus.timeout_count != '0) && (cnt_q >= bus.timeout_count);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_inc;
        high_tmp_d = high_tmp_q;
        high_d     = high_q;
        low_d      = low_q;
        period_d   = period_q;
        valid_d    = 1'b0;
        tmo_d      = 1'b0;
        present_d  = present_q;

        if (!bus.enable) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            present_d = 1'b0;
        end else if (state_q == ST_IDLE) begin
            state_d = ST_ARM;
            cnt_d   = '0;
        end else if (timeout_hit) begin
            // Timeout beats a coincident edge; the counter restarts so it fires once per window.
            tmo_d     = 1'b1;
            present_d = 1'b0;
            state_d   = ST_ARM;
            cnt_d     = CNT_ONE;
        end else begin
            case (state_q)
                ST_ARM: begin
                    if (rise) begin
                        state_d = ST_HIGH;
                        cnt_d   = CNT_ONE;
                    end else if (fall) begin
                        cnt_d = CNT_ONE;
                    end
                end
                ST_HIGH: begin
                    if (fall) begin
                        high_tmp_d = cnt_q;
                        state_d    = ST_LOW;
                        cnt_d      = CNT_ONE;
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        high_d    = high_tmp_q;
                        low_d     = cnt_q;
                        period_d  = WIDTH'(sat_add(64'(high_tmp_q), 64'(cnt_q), WIDTH));
                        valid_d   = 1'b1;
                        present_d = 1'b1;
                        state_d   = ST_HIGH;
                        cnt_d     = CNT_ONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge inclk) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            high_tmp_q <= '0;
            high_q     <= '0;
            low_q      <= '0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            tmo_q      <= 1'b0;
            present_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            high_tmp_q <= high_tmp_d;
            high_q     <= high_d;
            low_q      <= low_d;
            period_q   <= period_d;
            valid_q    <= valid_d;
            tmo_q      <= tmo_d;
            present_q  <= present_d;
        end
    end

    assign bus.high_count     = high_q;
    assign bus.low_count      = low_q;
    assign bus.period_count   = period_q;
    assign bus.meas_valid     = valid_q;
    assign bus.timeout        = tmo_q;
    assign bus.signal_present = present_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// tb/tb_clk_period_meter.sv - self-checking bench for clk_period_meter
module tb_clk_period_meter;

    logic        inclk;
    logic        Reset;
    logic        sig_in;
    logic        enable;
    logic [31:0] tmo32;

    clk_period_meter_if #(.WIDTH(32)) if32 ();
    clk_period_meter_if #(.WIDTH(8))  if8 ();

    assign if32.enable        = enable;
    assign if32.timeout_count = tmo32;
    assign if8.enable         = enable;
    assign if8.timeout_count  = 8'd0;

    clk_period_meter #(.WIDTH(32), .SYNC_STAGES(2)) dut (
        .inclk  (inclk),
        .Reset  (Reset),
        .sig_in (sig_in),
        .bus    (if32)
    );

    clk_period_meter #(.WIDTH(8), .SYNC_STAGES(2)) dut8 (
        .inclk  (inclk),
        .Reset  (Reset),
        .sig_in (sig_in),
        .bus    (if8)
    );

    initial inclk = 1'b0;
    always #5 inclk = ~inclk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] got_h[$], got_l[$], got_p[$];
    logic [7:0]  got8_h[$], got8_l[$], got8_p[$];
    logic [31:0] exp_h[$], exp_l[$], exp_p[$];
    int          to_count;
    int          to_cyc;
    logic        sp_at_to;
    logic [31:0] h_at_to;

    always @(posedge inclk) cyc++;

    always @(negedge inclk) begin
        if (if32.meas_valid) begin
            got_h.push_back(if32.high_count);
            got_l.push_back(if32.low_count);
            got_p.push_back(if32.period_count);
        end
        if (if8.meas_valid) begin
            got8_h.push_back(if8.high_count);
            got8_l.push_back(if8.low_count);
            got8_p.push_back(if8.period_count);
        end
        if (if32.timeout) begin
            to_count++;
            to_cyc   = cyc;
            sp_at_to = if32.signal_present;
            h_at_to  = if32.high_count;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge inclk);
        #1;
    endtask

    task automatic drive_phase(input logic lvl, input int n);
        sig_in = lvl;
        tick(n);
    endtask

    // Each complete high/low pair terminated by a later rise yields one measurement.
    task automatic drive_pair(input int h, input int l);
        drive_phase(1'b1, h);
        drive_phase(1'b0, l);
        exp_h.push_back(32'(h));
        exp_l.push_back(32'(l));
        exp_p.push_back(32'(h + l));
    endtask

    task automatic clear_logs();
        got_h.delete(); got_l.delete(); got_p.delete();
        got8_h.delete(); got8_l.delete(); got8_p.delete();
        exp_h.delete(); exp_l.delete(); exp_p.delete();
        to_count = 0;
    endtask

    task automatic start_test();
        enable = 1'b0;
        sig_in = 1'b0;
        tick(8);
        clear_logs();
        enable = 1'b1;
        tick(6);
    endtask

    task automatic end_test();
        enable = 1'b0;
        sig_in = 1'b0;
        tick(8);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick(3);
        checks++;
        if (if32.high_count !== 32'd0 || if32.low_count !== 32'd0 || if32.period_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_counts: got %0d/%0d/%0d required 0/0/0",
                     if32.high_count, if32.low_count, if32.period_count);
        end
        checks++;
        if (if32.meas_valid !== 1'b0 || if32.timeout !== 1'b0 || if32.signal_present !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got valid=%b tmo=%b present=%b required 0/0/0",
                     if32.meas_valid, if32.timeout, if32.signal_present);
        end
        checks++;
        if (if8.high_count !== 8'd0 || if8.period_count !== 8'd0 || if8.signal_present !== 1'b0) begin
            errors++;
            $display("FAIL reset_w8: got %0d/%0d/%b required 0/0/0",
                     if8.high_count, if8.period_count, if8.signal_present);
        end
        Reset = 1'b0;
        tick(2);
    endtask

    task automatic test_div4();
        start_test();
        for (int i = 0; i < 3; i++) drive_pair(4, 4);
        drive_phase(1'b1, 8);
        checks++;
        if (got_h.size() != exp_h.size()) begin
            errors++;
            $display("FAIL div4_count: got %0d required %0d", got_h.size(), exp_h.size());
        end
        for (int i = 0; i < exp_h.size() && i < got_h.size(); i++) begin
            checks++;
            if (got_h[i] !== exp_h[i] || got_l[i] !== exp_l[i] || got_p[i] !== exp_p[i]) begin
                errors++;
                $display("FAIL div4_meas[%0d]: got %0d/%0d/%0d required %0d/%0d/%0d",
                         i, got_h[i], got_l[i], got_p[i], exp_h[i], exp_l[i], exp_p[i]);
            end
        end
        checks++;
        if (if32.signal_present !== 1'b1) begin
            errors++;
            $display("FAIL div4_present: got %b required 1", if32.signal_present);
        end
        end_test();
    endtask

    task automatic test_mid_high();
        enable = 1'b0;
        sig_in = 1'b1;
        tick(8);
        clear_logs();
        enable = 1'b1;
        drive_phase(1'b1, 3);
        drive_phase(1'b0, 3);
        for (int i = 0; i < 4; i++) drive_pair(5, 3);
        drive_phase(1'b1, 8);
        checks++;
        if (got_h.size() != exp_h.size()) begin
            errors++;
            $display("FAIL midhigh_count: got %0d required %0d", got_h.size(), exp_h.size());
        end
        for (int i = 0; i < exp_h.size() && i < got_h.size(); i++) begin
            checks++;
            if (got_h[i] !== exp_h[i] || got_l[i] !== exp_l[i] || got_p[i] !== exp_p[i]) begin
                errors++;
                $display("FAIL midhigh_meas[%0d]: got %0d/%0d/%0d required %0d/%0d/%0d",
                         i, got_h[i], got_l[i], got_p[i], exp_h[i], exp_l[i], exp_p[i]);
            end
        end
        end_test();
    endtask

    task automatic test_random();
        start_test();
        for (int i = 0; i < 8; i++) drive_pair(int'($urandom_range(1, 15)), int'($urandom_range(1, 15)));
        drive_phase(1'b1, 8);
        checks++;
        if (got_h.size() != exp_h.size()) begin
            errors++;
            $display("FAIL random_count: got %0d required %0d", got_h.size(), exp_h.size());
        end
        for (int i = 0; i < exp_h.size() && i < got_h.size(); i++) begin
            checks++;
            if (got_h[i] !== exp_h[i] || got_l[i] !== exp_l[i] || got_p[i] !== exp_p[i]) begin
                errors++;
                $display("FAIL random_meas[%0d]: got %0d/%0d/%0d required %0d/%0d/%0d",
                         i, got_h[i], got_l[i], got_p[i], exp_h[i], exp_l[i], exp_p[i]);
            end
        end
        end_test();
    endtask

    task automatic test_timeout();
        int rise_cyc;
        tmo32 = 32'd20;
        start_test();
        drive_pair(5, 3);
        rise_cyc = cyc;
        drive_phase(1'b1, 30);
        drive_phase(1'b0, 3);
        drive_pair(5, 3);
        drive_pair(5, 3);
        drive_phase(1'b1, 8);
        checks++;
        if (to_count != 1) begin
            errors++;
            $display("FAIL timeout_pulses: got %0d required 1", to_count);
        end
        checks++;
        if (to_count > 0 && (to_cyc - rise_cyc < 20 || to_cyc - rise_cyc > 26)) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles required 20..26", to_cyc - rise_cyc);
        end
        checks++;
        if (sp_at_to !== 1'b0 || h_at_to !== 32'd5) begin
            errors++;
            $display("FAIL timeout_hold: got present=%b high=%0d required present=0 high=5",
                     sp_at_to, h_at_to);
        end
        checks++;
        if (got_h.size() != exp_h.size()) begin
            errors++;
            $display("FAIL timeout_count: got %0d required %0d", got_h.size(), exp_h.size());
        end
        for (int i = 0; i < exp_h.size() && i < got_h.size(); i++) begin
            checks++;
            if (got_h[i] !== exp_h[i] || got_l[i] !== exp_l[i] || got_p[i] !== exp_p[i]) begin
                errors++;
                $display("FAIL timeout_meas[%0d]: got %0d/%0d/%0d required %0d/%0d/%0d",
                         i, got_h[i], got_l[i], got_p[i], exp_h[i], exp_l[i], exp_p[i]);
            end
        end
        end_test();
        tmo32 = 32'd0;
    endtask

    task automatic test_disable_low();
        start_test();
        drive_pair(5, 3);
        drive_phase(1'b1, 5);
        drive_phase(1'b0, 5);
        enable = 1'b0;
        tick(3);
        checks++;
        if (got_h.size() != 1 || if32.signal_present !== 1'b0) begin
            errors++;
            $display("FAIL disable_discard: got %0d meas present=%b required 1 meas present=0",
                     got_h.size(), if32.signal_present);
        end
        checks++;
        if (if32.high_count !== 32'd5 || if32.low_count !== 32'd3 || if32.period_count !== 32'd8) begin
            errors++;
            $display("FAIL disable_hold: got %0d/%0d/%0d required 5/3/8",
                     if32.high_count, if32.low_count, if32.period_count);
        end
        enable = 1'b1;
        tick(4);
        drive_pair(6, 2);
        drive_phase(1'b1, 8);
        checks++;
        if (got_h.size() != exp_h.size()) begin
            errors++;
            $display("FAIL disable_count: got %0d required %0d", got_h.size(), exp_h.size());
        end
        for (int i = 0; i < exp_h.size() && i < got_h.size(); i++) begin
            checks++;
            if (got_h[i] !== exp_h[i] || got_l[i] !== exp_l[i] || got_p[i] !== exp_p[i]) begin
                errors++;
                $display("FAIL disable_meas[%0d]: got %0d/%0d/%0d required %0d/%0d/%0d",
                         i, got_h[i], got_l[i], got_p[i], exp_h[i], exp_l[i], exp_p[i]);
            end
        end
        end_test();
    endtask

    task automatic test_reset_mid_high();
        start_test();
        drive_pair(5, 3);
        drive_phase(1'b1, 6);
        Reset  = 1'b1;
        sig_in = 1'b0;
        tick(1);
        checks++;
        if (if32.high_count !== 32'd0 || if32.low_count !== 32'd0 || if32.period_count !== 32'd0 ||
            if32.signal_present !== 1'b0 || if32.meas_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: got %0d/%0d/%0d present=%b required 0/0/0 present=0",
                     if32.high_count, if32.low_count, if32.period_count, if32.signal_present);
        end
        Reset = 1'b0;
        tick(6);
        clear_logs();
        for (int i = 0; i < 4; i++) drive_pair(1, 1);
        drive_phase(1'b1, 8);
        checks++;
        if (got_h.size() != exp_h.size()) begin
            errors++;
            $display("FAIL glitch_count: got %0d required %0d", got_h.size(), exp_h.size());
        end
        for (int i = 0; i < exp_h.size() && i < got_h.size(); i++) begin
            checks++;
            if (got_h[i] !== exp_h[i] || got_l[i] !== exp_l[i] || got_p[i] !== exp_p[i]) begin
                errors++;
                $display("FAIL glitch_meas[%0d]: got %0d/%0d/%0d required %0d/%0d/%0d",
                         i, got_h[i], got_l[i], got_p[i], exp_h[i], exp_l[i], exp_p[i]);
            end
        end
        end_test();
    endtask

    task automatic test_saturation();
        int h8, p8;
        start_test();
        drive_pair(300, 10);
        drive_phase(1'b1, 8);
        h8 = (300 > 255) ? 255 : 300;
        p8 = (h8 + 10 > 255) ? 255 : h8 + 10;
        checks++;
        if (got8_h.size() != 1) begin
            errors++;
            $display("FAIL sat8_count: got %0d required 1", got8_h.size());
        end else begin
            checks++;
            if (got8_h[0] !== 8'(h8) || got8_l[0] !== 8'd10 || got8_p[0] !== 8'(p8)) begin
                errors++;
                $display("FAIL sat8_meas: got %0d/%0d/%0d required %0d/10/%0d",
                         got8_h[0], got8_l[0], got8_p[0], h8, p8);
            end
        end
        checks++;
        if (got_h.size() != 1) begin
            errors++;
            $display("FAIL sat32_count: got %0d required 1", got_h.size());
        end else begin
            checks++;
            if (got_h[0] !== exp_h[0] || got_l[0] !== exp_l[0] || got_p[0] !== exp_p[0]) begin
                errors++;
                $display("FAIL sat32_meas: got %0d/%0d/%0d required %0d/%0d/%0d",
                         got_h[0], got_l[0], got_p[0], exp_h[0], exp_l[0], exp_p[0]);
            end
        end
        end_test();
    endtask

    initial begin
        Reset    = 1'b1;
        enable   = 1'b0;
        sig_in   = 1'b0;
        tmo32    = 32'd0;
        to_count = 0;
        to_cyc   = 0;
        sp_at_to = 1'b0;
        h_at_to  = 32'd0;
        test_reset();
        test_div4();
        test_mid_high();
        test_random();
        test_timeout();
        test_disable_low();
        test_reset_mid_high();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
